// File: rtl/wc_link_pkg.sv
// Shared constants and state type for the WC_3_4 host link engine.
package wc_link_pkg;

  localparam int unsigned W       = 10;
  localparam int unsigned NK      = 9;
  localparam int unsigned NT      = 16;
  localparam int unsigned NR      = 4;
  localparam int unsigned NF      = NK + NT;
  localparam int unsigned TIMEOUT = 64;

  localparam logic [W-1:0] SYNC      = 10'h2A5;
  localparam logic [W-1:0] IDLE_WORD = '0;

  localparam logic [4:0] NF_W     = 5'(NF);
  localparam logic [4:0] LAST_PAY = 5'(NF - 1);
  localparam logic [4:0] LAST_RES = 5'(NR - 1);
  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);
  localparam logic [6:0] TMO_MAX  = 7'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_WAIT,
    ST_RECV
  } link_state_t;

endpackage

// File: rtl/wc_link_fifo.sv
// Small synchronous first-word-fall-through FIFO; output reads 0 while empty.
module wc_link_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && (cnt_q != FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) begin
        wr_q <= (wr_q == LAST_IDX) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= (rd_q == LAST_IDX) ? '0 : rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/wc_link_host.sv
// Host end of the D/Z chip link: buffers one kernel+tile frame, sends it with a
// sync header on D, then captures the sync-framed result burst from Z.
module wc_link_host
  import wc_link_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] d_pin,
  input  logic [W-1:0] z_pin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         err_timeout
);

  link_state_t  state_q, state_d;
  logic [4:0]   wp_q, wp_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [6:0]   tmo_q, tmo_d;
  logic [W-1:0] d_pin_q, d_pin_d;
  logic [W-1:0] z_q;
  logic [W-1:0] frame_q [NF];

  logic accept, wp_clr, push, pop, fifo_empty;

  // in_ready looks at next state so the HDR decision blocks the same-cycle write.
  assign in_ready  = (wp_q < NF_W) && (state_d != ST_HDR) && (state_d != ST_PAY);
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign busy      = (state_q != ST_IDLE);
  assign d_pin     = d_pin_q;

  always_comb begin
    wp_d = wp_q;
    if (wp_clr) begin
      wp_d = '0;
    end else if (accept) begin
      wp_d = wp_q + 5'd1;
    end
  end

  // d_pin is registered, so the word for the coming state is chosen here.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    d_pin_d     = IDLE_WORD;
    push        = 1'b0;
    wp_clr      = 1'b0;
    err_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wp_q == NF_W && fifo_empty) begin
          state_d = ST_HDR;
          d_pin_d = SYNC;
        end
      end
      ST_HDR: begin
        state_d = ST_PAY;
        cnt_d   = '0;
        d_pin_d = frame_q[0];
      end
      ST_PAY: begin
        if (cnt_q == LAST_PAY) begin
          state_d = ST_WAIT;
          tmo_d   = '0;
          wp_clr  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          d_pin_d = frame_q[cnt_q + 5'd1];
        end
      end
      ST_WAIT: begin
        if (z_q == SYNC) begin
          state_d = ST_RECV;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_IDLE;
          err_timeout = 1'b1;
          tmo_d       = TMO_MAX;
        end else begin
          tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 7'd1;
        end
      end
      ST_RECV: begin
        push = 1'b1;
        if (cnt_q == LAST_RES) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      d_pin_q <= IDLE_WORD;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      d_pin_q <= d_pin_d;
      z_q     <= z_pin;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      frame_q[wp_q] <= in_data;
    end
  end

  wc_link_fifo #(
    .DW    (W),
    .DEPTH (NR)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (z_q),
    .pop_i   (pop),
    .data_o  (out_data),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_wc_link_host.sv
// Directed bench for wc_link_host with a cycle-exact chip model on Z.
module tb_wc_link_host;
  import wc_link_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] d_pin;
  logic [W-1:0] z_pin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic         err_timeout;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] fr [NF];
  logic [W-1:0] rs [NR];

  wc_link_host dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .d_pin       (d_pin),
    .z_pin       (z_pin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame;
    for (int k = 0; k < int'(NF); k++) begin
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = fr[k];
      while (!in_ready && n < 200) begin
        tick;
        n++;
      end
      if (n >= 200) check_eq($sformatf("load_stall%0d", k), 32'(n), 32'(0));
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_hdr(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (d_pin !== SYNC && n < 300) begin
      tick;
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp_lat));
  endtask

  task automatic check_payload;
    for (int k = 0; k < int'(NF); k++) begin
      tick;
      check_eq($sformatf("pay%0d", k), 32'(d_pin), 32'(fr[k]));
    end
    tick;
    check_eq("pay_end", 32'(d_pin), 32'(IDLE_WORD));
  endtask

  task automatic chip_reply(input int idle);
    for (int i = 0; i < idle; i++) begin
      z_pin = '0;
      tick;
    end
    z_pin = SYNC;
    tick;
    z_pin = rs[0];
    tick;
    check_eq("rx_early", 32'(out_valid), 32'(0));
    z_pin = rs[1];
    tick;
    check_eq("rx_lat_valid", 32'(out_valid), 32'(1));
    check_eq("rx_lat_data", 32'(out_data), 32'(rs[0]));
    z_pin = rs[2];
    tick;
    z_pin = rs[3];
    tick;
    z_pin = '0;
  endtask

  task automatic drain;
    for (int k = 0; k < int'(NR); k++) begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        tick;
        n++;
      end
      check_eq($sformatf("res%0d", k), 32'(out_data), 32'(rs[k]));
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    check_eq("drain_empty", 32'(out_valid), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    int pulses;
    int first;
    int hdr_seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    z_pin     = '0;
    out_ready = 1'b0;
    tick;
    tick;
    check_eq("rst_d_pin", 32'(d_pin), 32'(0));
    check_eq("rst_in_ready", 32'(in_ready), 32'(1));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_out_data", 32'(out_data), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_err", 32'(err_timeout), 32'(0));
    rst = 1'b0;
    tick;

    // Basic frame 1..25, results after 5 idle cycles.
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'(k + 1);
    rs[0] = 10'h011; rs[1] = 10'h022; rs[2] = 10'h033; rs[3] = 10'h044;
    load_frame;
    check_eq("rdy_full", 32'(in_ready), 32'(0));
    wait_hdr("hdr_lat1", 1);
    check_eq("busy_hdr", 32'(busy), 32'(1));
    check_payload;
    check_eq("rdy_wait", 32'(in_ready), 32'(1));
    chip_reply(5);
    drain;
    check_eq("busy_idle1", 32'(busy), 32'(0));

    // SYNC value inside payload and inside results.
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'(k + 'h100);
    fr[7] = SYNC;
    rs[0] = SYNC; rs[1] = 10'h155; rs[2] = SYNC; rs[3] = 10'h3FF;
    load_frame;
    wait_hdr("hdr_lat2", 1);
    check_payload;
    chip_reply(3);
    drain;

    // No Z sync: timeout.
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'(25 - k);
    load_frame;
    wait_hdr("hdr_lat3", 1);
    check_payload;
    pulses = 0;
    first  = -1;
    for (int i = 0; i < 80; i++) begin
      if (err_timeout) begin
        pulses++;
        if (first < 0) first = i;
      end
      tick;
    end
    check_eq("tmo_pulses", 32'(pulses), 32'(1));
    check_eq("tmo_cycle", 32'(first), 32'(63));
    check_eq("tmo_busy", 32'(busy), 32'(0));
    check_eq("tmo_no_valid", 32'(out_valid), 32'(0));
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'(k * 3);
    rs[0] = 10'h001; rs[1] = 10'h002; rs[2] = 10'h003; rs[3] = 10'h004;
    load_frame;
    wait_hdr("hdr_lat4", 1);
    check_payload;
    chip_reply(0);
    drain;

    // Back-to-back: frame B buffered during WAIT, results held by out_ready=0.
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'(k + 'h200);
    load_frame;
    wait_hdr("hdr_lat5", 1);
    check_payload;
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'('h3FF - k);
    load_frame;
    check_eq("b2b_rdy_full", 32'(in_ready), 32'(0));
    rs[0] = 10'h0AA; rs[1] = 10'h0BB; rs[2] = 10'h0CC; rs[3] = 10'h0DD;
    chip_reply(0);
    hdr_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (d_pin === SYNC) hdr_seen++;
    end
    check_eq("hold_no_hdr", 32'(hdr_seen), 32'(0));
    check_eq("hold_valid", 32'(out_valid), 32'(1));
    drain;
    check_eq("b2b_p1", 32'(d_pin), 32'(0));
    tick;
    check_eq("b2b_hdr", 32'(d_pin), 32'(SYNC));
    check_payload;
    rs[0] = 10'h101; rs[1] = 10'h202; rs[2] = 10'h303; rs[3] = 10'h104;
    chip_reply(2);
    drain;

    // Reset during payload word 12.
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'(k + 'h50);
    load_frame;
    wait_hdr("hdr_lat6", 1);
    for (int k = 0; k <= 12; k++) begin
      tick;
      check_eq($sformatf("pre_rst%0d", k), 32'(d_pin), 32'(fr[k]));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("abort_d_pin", 32'(d_pin), 32'(0));
    check_eq("abort_in_ready", 32'(in_ready), 32'(1));
    check_eq("abort_busy", 32'(busy), 32'(0));
    for (int k = 0; k < int'(NF); k++) fr[k] = 10'(k * 37 + 5);
    load_frame;
    wait_hdr("hdr_lat7", 1);
    check_payload;
    rs[0] = 10'h2A4; rs[1] = 10'h001; rs[2] = 10'h3FE; rs[3] = 10'h0F0;
    chip_reply(1);
    drain;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wc_link_host.md
# wc_link_host

Host-side link engine for the WC_3_4 Winograd chip pin interface. It collects one kernel-plus-tile frame from a valid/ready upstream, serialises it onto the 10-bit `D` pins with a sync header, then waits for and captures the framed 4-word result burst returned on the 10-bit `Z` pins. It sits in the FPGA/tester fabric facing the chip pads, as the opposite end of the `D`/`Z` link.

## Interface
- `W`, 10, link and data word width (must equal chip pin width)
- `NK`, 9, kernel words per frame (3x3)
- `NT`, 16, tile words per frame (4x4)
- `NR`, 4, result words per frame (2x2)
- `SYNC`, 10'h2A5, frame header word on both `D` and `Z`
- `TIMEOUT`, 64, max cycles from last payload word to `Z` sync

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  block accepts word this cycle
- `in_data`  in  W  kernel words 0..8 then tile words 0..15
- `d_pin`  out  W  registered drive to chip `D`
- `z_pin`  in  W  chip `Z` output
- `out_valid`  out  1  result word valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  W  result words 0..3 in order
- `busy`  out  1  link FSM not in IDLE
- `err_timeout`  out  1  one-cycle pulse on timeout

## Operation
- Frame buffer: 25 x W, write pointer `wp` (0..25). A word is accepted when `in_valid && in_ready`; `in_ready = (wp < 25) && state ∉ {HDR, PAY}`.
- Link FSM states: IDLE, HDR, PAY, WAIT, RECV.
  - IDLE: `d_pin` = 0. Go to HDR when `wp == 25` and the result FIFO is empty.
  - HDR: `d_pin` = SYNC for one cycle, then PAY.
  - PAY: `d_pin` = buf[0..24] on 25 consecutive cycles with no gaps. After the last word, `wp` clears to 0, the timeout counter clears, and the FSM enters WAIT.
  - WAIT: `d_pin` = 0. Buffer refill is allowed. `z_q == SYNC` moves to RECV. The counter reaching TIMEOUT pulses `err_timeout` and returns to IDLE; no results are produced for that frame.
  - RECV: capture `z_q` on the next NR consecutive cycles into the result FIFO, then go to IDLE.
- `z_pin` is registered once (`z_q`) before any comparison.
- A SYNC on `z_q` outside WAIT is ignored.
- SYNC inside payload or result data is not special; only the state decides.
- Result FIFO: 4 deep, first-word-fall-through. `out_valid` = not empty. Entry to HDR requires an empty FIFO, so RECV never overflows.
- Data is passed bit-exact with no arithmetic. Counters are 5 bits for PAY and 7 bits for timeout, and saturate at the terminal value.

## Timing
- Reset values: `d_pin`=0, `in_ready`=1, `out_valid`=0, `out_data`=0, `busy`=0, `err_timeout`=0. `wp`, FIFO and counters clear; state = IDLE.
- `rst` mid-frame aborts immediately. `d_pin` returns to 0 on the next edge and buffered words are discarded.
- Send timing: with the 25th word accepted at cycle t, HDR is on `d_pin` at t+2 and payload occupies t+3..t+27.
- Receive timing: SYNC present on `z_pin` at cycle s appears on `z_q` at s+1. Result word k is taken from `z_pin` at s+1+k and is visible on `out_data` at s+3+k.
- If `in_valid` and FSM entry to HDR coincide, HDR wins. `in_ready` drops in the same cycle as the HDR decision, combinationally from next-state.

## Structure
- Shared package `wc_link_pkg`: `W`, `SYNC`, `NK`/`NT`/`NR`, state enum `link_state_t`, and the idle-word constant 0.
- One sub-module: `wc_link_fifo` (parameterised sync FIFO, FWFT, used for results).
- The frame buffer is inline register array.

## Test plan
- Reset, then stream words 1..25, then a chip model returns SYNC followed by 0x011, 0x022, 0x033, 0x044 after 5 idle cycles. Required: `d_pin` shows 0x2A5 then 1..25; `out_data` delivers 0x011..0x044 in order.
- Payload contains 0x2A5 at word 7, and the chip model echoes SYNC inside the results. Required: the link is unaffected and all data is exact.
- No Z SYNC for 64 cycles. Required: `err_timeout` pulses once, the FSM is back in IDLE with no `out_valid`, and the next frame sends normally.
- `out_ready`=0 holds 4 results while frame 2 is fully buffered. Required: HDR is not issued until the FIFO drains.
- Back-to-back: frame 2 is written during WAIT of frame 1. Required: HDR for frame 2 appears 2 cycles after the last result of frame 1 is popped.
- `rst` asserted on payload word 12. Required: `d_pin`=0 next cycle, `in_ready`=1, and a fresh 25-word frame sends correctly.
